ping_sequencer: RTL and testbench
=================================

// Module: ping_sequencer
// PURPOSE
//  Drives the state input of h_bridge, i.e. the `HB_* codes from dvl_params.sv, for one acoustic ping per start pulse.
//  Each ping runs four phases: transmit burst (OSCL), ring-down damping (DAMP), receiver blanking (HIGHZ) and listen (HIGHZ, rx_en=1).
//  Sits between the host/control register block and h_bridge. Also gates the receive sampling path.
// PARAMETERS
//  CARRIER_CLKS  64  clk cycles per carrier period (matches the h_bridge divide-by-2^6)
//  BURST_W       8   width of burst_len (carrier periods)
//  DAMP_W        12  width of damp_len (clk cycles)
//  BLANK_W       16  width of blank_len (clk cycles)
//  LISTEN_W      20  width of listen_len (clk cycles)
// PORTS
//  clk         in   1         system clock, 48 MHz
//  rst         in   1         asynchronous reset, active-high
//  start       in   1         1-cycle request to begin a ping
//  abort       in   1         terminate the current ping early
//  burst_len   in   BURST_W   burst length, in carrier periods
//  damp_len    in   DAMP_W    damping length, in clk cycles
//  blank_len   in   BLANK_W   blanking length, in clk cycles
//  listen_len  in   LISTEN_W  listen window, in clk cycles
//  hb_state    out  2         to h_bridge state: `HB_HIGHZ / `HB_DAMP / `HB_OSCL
//  busy        out  1         high from the cycle after start is accepted until the return to IDLE
//  rx_en       out  1         high only in LISTEN
//  done        out  1         1-cycle pulse on completion of LISTEN, or on abort
// BEHAVIOUR
//  Reset (async): state=IDLE, hb_state=`HB_HIGHZ, busy=0, rx_en=0, done=0, all counters=0.
//  All outputs are registered. No output is decoded combinationally from the inputs.
//  FSM states: IDLE, BURST, DAMP, BLANK, LISTEN.
//   IDLE: start=1 latches all four *_len inputs into shadow registers.
//    - Next state is the first phase whose length is non-zero, in the order BURST, DAMP, BLANK, LISTEN.
//    - If all four lengths are 0, stay in IDLE and pulse done the next cycle.
//   BURST: hb_state=`HB_OSCL. Lasts exactly burst_len*CARRIER_CLKS cycles.
//   DAMP: hb_state=`HB_DAMP. Lasts damp_len cycles.
//   BLANK: hb_state=`HB_HIGHZ, rx_en=0. Lasts blank_len cycles.
//   LISTEN: hb_state=`HB_HIGHZ, rx_en=1. Lasts listen_len cycles, then go to IDLE and pulse done.
//  Phase skipping: a phase whose length is 0 is skipped with no idle cycle, so the next phase starts immediately.
//  Phase counter: one down-counter, loaded on entry to each phase with (length-1); the phase ends when the counter is 0.
//   - BURST count = {burst_len, log2(CARRIER_CLKS) zero bits} - 1. Computed at BURST_W+6 bits; must not overflow.
//  Latency: start in cycle N -> hb_state and busy change in cycle N+1.
//  start while busy=1: ignored. The shadow lengths are not reloaded.
//  Changing *_len while busy has no effect on the ping in progress.
//  abort (level, sampled each cycle; priority over normal transitions):
//   - BURST -> DAMP with the full shadow damp_len. If damp_len=0, go to IDLE instead. The transducer is always damped after a drive.
//   - DAMP: completes normally, then IDLE. BLANK and LISTEN are skipped.
//   - BLANK or LISTEN -> IDLE immediately.
//   - done pulses once on the return to IDLE.
//   - abort in IDLE: no effect. abort and start in the same IDLE cycle: start wins.
//  done and busy: done=1 in the first IDLE cycle, with busy=0 in that same cycle.
//   - A start in that cycle is accepted (back-to-back pings).
//  Reset mid-ping: hb_state returns to `HB_HIGHZ asynchronously. No damp phase is forced.
//  hb_state never takes the unused 2-bit code.
// TESTING
//  1. burst=2, damp=10, blank=5, listen=8, start -> 128 cyc OSCL, 10 DAMP, 5 HIGHZ with rx_en=0, 8 with rx_en=1, then done.
//  2. burst=0, damp=0, blank=3, listen=0 -> 3 cycles HIGHZ/busy, then done. All-zero lengths -> done only, busy never asserted.
//  3. abort at cycle 20 of BURST (damp=10) -> DAMP for 10 cycles, then IDLE and done. rx_en never rises.
//  4. start pulsed mid-LISTEN, and *_len changed -> ignored. start in the done cycle -> new ping begins the next cycle.
//  5. rst asserted mid-BURST between clock edges -> hb_state=`HB_HIGHZ and busy=0 immediately. Normal ping after release.
//  6. burst=255 -> OSCL for exactly 16320 cycles, with no counter overflow.

Source files
------------

// File: rtl/ping_sequencer.sv
// Sequences one acoustic ping per start pulse: transmit burst, ring-down damping,
// receiver blanking and listen. It drives the h_bridge state code and gates the receive path.
module ping_sequencer #(
    parameter int CARRIER_CLKS = 64,
    parameter int BURST_W      = 8,
    parameter int DAMP_W       = 12,
    parameter int BLANK_W      = 16,
    parameter int LISTEN_W     = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic [BURST_W-1:0]  burst_len,
    input  logic [DAMP_W-1:0]   damp_len,
    input  logic [BLANK_W-1:0]  blank_len,
    input  logic [LISTEN_W-1:0] listen_len,
    output logic [1:0]          hb_state,
    output logic                busy,
    output logic                rx_en,
    output logic                done
);

    // h_bridge state codes; these mirror the HB_* definitions in dvl_params.sv, and 2'b11 is never driven
    localparam logic [1:0] HB_HIGHZ = 2'b00;
    localparam logic [1:0] HB_DAMP  = 2'b01;
    localparam logic [1:0] HB_OSCL  = 2'b10;

    localparam int CAR_W = $clog2(CARRIER_CLKS);
    localparam int BC_W  = BURST_W + CAR_W;
    localparam int CW_A  = (BC_W > DAMP_W) ? BC_W : DAMP_W;
    localparam int CW_B  = (BLANK_W > LISTEN_W) ? BLANK_W : LISTEN_W;
    localparam int CNT_W = (CW_A > CW_B) ? CW_A : CW_B;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        BURST  = 3'd1,
        DAMP   = 3'd2,
        BLANK  = 3'd3,
        LISTEN = 3'd4
    } state_t;

    typedef struct packed {
        state_t             st;
        logic [CNT_W-1:0]   cnt;
    } entry_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                abort_q, abort_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [DAMP_W-1:0]   damp_q, damp_d;
    logic [BLANK_W-1:0]  blank_q, blank_d;
    logic [LISTEN_W-1:0] listen_q, listen_d;
    logic [1:0]          hb_state_q, hb_state_d;
    logic                busy_q, busy_d;
    logic                rx_en_q, rx_en_d;
    logic                done_q, done_d;
    entry_t              nxt;

    // First phase at or after `from` with a non-zero length, with its counter preload (length-1)
    function automatic entry_t enter_from(
        input state_t              from,
        input logic [BURST_W-1:0]  b,
        input logic [DAMP_W-1:0]   d,
        input logic [BLANK_W-1:0]  k,
        input logic [LISTEN_W-1:0] l
    );
        entry_t           e;
        logic [BC_W-1:0]  bc;
        bc    = {b, {CAR_W{1'b0}}} - BC_W'(1);
        e.st  = IDLE;
        e.cnt = '0;
        if (from == BURST && b != '0) begin
            e.st  = BURST;
            e.cnt = CNT_W'(bc);
        end else if ((from inside {BURST, DAMP}) && d != '0) begin
            e.st  = DAMP;
            e.cnt = CNT_W'(d - DAMP_W'(1));
        end else if ((from inside {BURST, DAMP, BLANK}) && k != '0) begin
            e.st  = BLANK;
            e.cnt = CNT_W'(k - BLANK_W'(1));
        end else if (l != '0) begin
            e.st  = LISTEN;
            e.cnt = CNT_W'(l - LISTEN_W'(1));
        end
        return e;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        abort_d  = abort_q;
        burst_d  = burst_q;
        damp_d   = damp_q;
        blank_d  = blank_q;
        listen_d = listen_q;
        nxt.st   = IDLE;
        nxt.cnt  = '0;

        case (state_q)
            IDLE: begin
                abort_d = 1'b0;
                if (start) begin
                    burst_d  = burst_len;
                    damp_d   = damp_len;
                    blank_d  = blank_len;
                    listen_d = listen_len;
                    nxt      = enter_from(BURST, burst_len, damp_len, blank_len, listen_len);
                    state_d  = nxt.st;
                    cnt_d    = nxt.cnt;
                end
            end
            BURST: begin
                // An aborted drive still gets its full damping before the ping ends
                if (abort) begin
                    abort_d = 1'b1;
                    if (damp_q != '0) begin
                        state_d = DAMP;
                        cnt_d   = CNT_W'(damp_q - DAMP_W'(1));
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == '0) begin
                    nxt     = enter_from(DAMP, burst_q, damp_q, blank_q, listen_q);
                    state_d = nxt.st;
                    cnt_d   = nxt.cnt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DAMP: begin
                abort_d = abort_q | abort;
                if (cnt_q == '0) begin
                    if (abort_d) begin
                        state_d = IDLE;
                    end else begin
                        nxt     = enter_from(BLANK, burst_q, damp_q, blank_q, listen_q);
                        state_d = nxt.st;
                        cnt_d   = nxt.cnt;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            BLANK: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (cnt_q == '0) begin
                    nxt     = enter_from(LISTEN, burst_q, damp_q, blank_q, listen_q);
                    state_d = nxt.st;
                    cnt_d   = nxt.cnt;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            LISTEN: begin
                if (abort || cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_d == IDLE) begin
            cnt_d = '0;
        end

        // Outputs are registered from the next state, so they follow start by exactly one cycle
        case (state_d)
            BURST:   hb_state_d = HB_OSCL;
            DAMP:    hb_state_d = HB_DAMP;
            default: hb_state_d = HB_HIGHZ;
        endcase
        busy_d  = (state_d != IDLE);
        rx_en_d = (state_d == LISTEN);
        done_d  = ((state_q != IDLE) || start) && (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            burst_q    <= '0;
            damp_q     <= '0;
            blank_q    <= '0;
            listen_q   <= '0;
            hb_state_q <= HB_HIGHZ;
            busy_q     <= 1'b0;
            rx_en_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            burst_q    <= burst_d;
            damp_q     <= damp_d;
            blank_q    <= blank_d;
            listen_q   <= listen_d;
            hb_state_q <= hb_state_d;
            busy_q     <= busy_d;
            rx_en_q    <= rx_en_d;
            done_q     <= done_d;
        end
    end

    assign hb_state = hb_state_q;
    assign busy     = busy_q;
    assign rx_en    = rx_en_q;
    assign done     = done_q;

endmodule

// File: tb/tb_ping_sequencer.sv
// Self-checking bench for ping_sequencer: a per-cycle expected output stream is queued
// when each ping is launched and is compared against the DUT on every falling edge.
module tb_ping_sequencer;

    localparam logic [1:0] HB_HIGHZ = 2'b00;
    localparam logic [1:0] HB_DAMP  = 2'b01;
    localparam logic [1:0] HB_OSCL  = 2'b10;

    // Expected-sample encoding {hb_state, busy, rx_en, done}
    localparam logic [4:0] V_OSCL   = {HB_OSCL,  1'b1, 1'b0, 1'b0};
    localparam logic [4:0] V_DAMP   = {HB_DAMP,  1'b1, 1'b0, 1'b0};
    localparam logic [4:0] V_BLANK  = {HB_HIGHZ, 1'b1, 1'b0, 1'b0};
    localparam logic [4:0] V_LISTEN = {HB_HIGHZ, 1'b1, 1'b1, 1'b0};
    localparam logic [4:0] V_DONE   = {HB_HIGHZ, 1'b0, 1'b0, 1'b1};
    localparam logic [4:0] V_IDLE   = {HB_HIGHZ, 1'b0, 1'b0, 1'b0};

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        abort;
    logic [7:0]  burst_len;
    logic [11:0] damp_len;
    logic [15:0] blank_len;
    logic [19:0] listen_len;
    logic [1:0]  hb_state;
    logic        busy;
    logic        rx_en;
    logic        done;

    int tests_run    = 0;
    int tests_failed = 0;
    logic [4:0] exp_q[$];

    ping_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .burst_len  (burst_len),
        .damp_len   (damp_len),
        .blank_len  (blank_len),
        .listen_len (listen_len),
        .hb_state   (hb_state),
        .busy       (busy),
        .rx_en      (rx_en),
        .done       (done)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic drive_lens(input int b, input int d, input int k, input int l);
        burst_len  = 8'(b);
        damp_len   = 12'(d);
        blank_len  = 16'(k);
        listen_len = 20'(l);
    endtask

    task automatic push_n(input int n, input logic [4:0] v);
        repeat (n) exp_q.push_back(v);
    endtask

    // Reference model: expands phase lengths (and an optional one-cycle abort) into per-cycle outputs
    task automatic model_ping(input int b, input int d, input int k, input int l,
                              input int ab_phase, input int ab_idx);
        int nb;
        nb = b * 64;
        if (b == 0 && d == 0 && k == 0 && l == 0) begin
            exp_q.push_back(V_DONE);
            return;
        end
        if (ab_phase == 1 && ab_idx < nb) begin
            push_n(ab_idx + 1, V_OSCL);
            push_n(d, V_DAMP);
            exp_q.push_back(V_DONE);
            return;
        end
        push_n(nb, V_OSCL);
        if (ab_phase == 2 && ab_idx < d) begin
            push_n(d, V_DAMP);
            exp_q.push_back(V_DONE);
            return;
        end
        push_n(d, V_DAMP);
        if (ab_phase == 3 && ab_idx < k) begin
            push_n(ab_idx + 1, V_BLANK);
            exp_q.push_back(V_DONE);
            return;
        end
        push_n(k, V_BLANK);
        if (ab_phase == 4 && ab_idx < l) begin
            push_n(ab_idx + 1, V_LISTEN);
            exp_q.push_back(V_DONE);
            return;
        end
        push_n(l, V_LISTEN);
        exp_q.push_back(V_DONE);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        tests_run++;
        if (hb_state !== HB_HIGHZ) begin
            tests_failed++;
            $display("[TB] FAIL reset_hb: got %0d, want %0d", hb_state, HB_HIGHZ);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_busy: got %b, want 0", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (rx_en !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_rx_en: got %b, want 0", rx_en);
        end
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_done: got %b, want 0", done);
        end
    endtask

    task automatic test_phases();
        int tb_b[6] = '{2, 0, 0, 1, 0, 255};
        int tb_d[6] = '{10, 0, 0, 0, 5, 0};
        int tb_k[6] = '{5, 3, 0, 0, 0, 0};
        int tb_l[6] = '{8, 0, 0, 4, 2, 1};
        logic [4:0] exp, obs;
        int c;
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            drive_lens(tb_b[t], tb_d[t], tb_k[t], tb_l[t]);
            start = 1'b1;
            model_ping(tb_b[t], tb_d[t], tb_k[t], tb_l[t], 0, -1);
            exp_q.push_back(V_IDLE);
            c = 0;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                start = 1'b0;
                exp = exp_q.pop_front();
                obs = {hb_state, busy, rx_en, done};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL phases[%0d] cyc %0d: got hb=%0d busy=%b rx_en=%b done=%b, want hb=%0d busy=%b rx_en=%b done=%b",
                             t, c, obs[4:3], obs[2], obs[1], obs[0], exp[4:3], exp[2], exp[1], exp[0]);
                end
                c++;
            end
        end
    endtask

    task automatic test_abort();
        int tb_b[6]  = '{2, 1, 0, 0, 1, 0};
        int tb_d[6]  = '{10, 4, 2, 0, 0, 3};
        int tb_k[6]  = '{5, 6, 6, 2, 3, 0};
        int tb_l[6]  = '{8, 5, 5, 5, 3, 0};
        int tb_ph[6] = '{1, 2, 3, 4, 1, 0};
        int tb_ix[6] = '{20, 1, 2, 3, 5, 0};
        logic [4:0] exp, obs;
        int c, nb, ab_cyc;
        for (int t = 0; t < 6; t++) begin
            nb = tb_b[t] * 64;
            case (tb_ph[t])
                1:       ab_cyc = tb_ix[t];
                2:       ab_cyc = nb + tb_ix[t];
                3:       ab_cyc = nb + tb_d[t] + tb_ix[t];
                4:       ab_cyc = nb + tb_d[t] + tb_k[t] + tb_ix[t];
                default: ab_cyc = -1;
            endcase
            @(negedge clk);
            drive_lens(tb_b[t], tb_d[t], tb_k[t], tb_l[t]);
            start = 1'b1;
            abort = (tb_ph[t] == 0);
            model_ping(tb_b[t], tb_d[t], tb_k[t], tb_l[t], tb_ph[t], tb_ix[t]);
            exp_q.push_back(V_IDLE);
            c = 0;
            while (exp_q.size() > 0) begin
                @(negedge clk);
                start = 1'b0;
                exp = exp_q.pop_front();
                obs = {hb_state, busy, rx_en, done};
                tests_run++;
                if (obs !== exp) begin
                    tests_failed++;
                    $display("[TB] FAIL abort[%0d] cyc %0d: got hb=%0d busy=%b rx_en=%b done=%b, want hb=%0d busy=%b rx_en=%b done=%b",
                             t, c, obs[4:3], obs[2], obs[1], obs[0], exp[4:3], exp[2], exp[1], exp[0]);
                end
                abort = (c == ab_cyc);
                c++;
            end
            abort = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp, obs;
        int c;
        bit launched;
        @(negedge clk);
        drive_lens(0, 3, 2, 6);
        start = 1'b1;
        model_ping(0, 3, 2, 6, 0, -1);
        c = 0;
        launched = 1'b0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            exp = exp_q.pop_front();
            obs = {hb_state, busy, rx_en, done};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL back_to_back cyc %0d: got hb=%0d busy=%b rx_en=%b done=%b, want hb=%0d busy=%b rx_en=%b done=%b",
                         c, obs[4:3], obs[2], obs[1], obs[0], exp[4:3], exp[2], exp[1], exp[0]);
            end
            if (c == 7) begin
                start = 1'b1;
                drive_lens(5, 7, 9, 11);
            end
            if (exp[0] && !launched) begin
                launched = 1'b1;
                drive_lens(0, 2, 1, 2);
                start = 1'b1;
                model_ping(0, 2, 1, 2, 0, -1);
                exp_q.push_back(V_IDLE);
            end
            c++;
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0] exp, obs;
        int c;
        @(negedge clk);
        drive_lens(1, 0, 0, 1);
        start = 1'b1;
        model_ping(1, 0, 0, 1, 0, -1);
        for (c = 0; c < 10; c++) begin
            @(negedge clk);
            start = 1'b0;
            exp = exp_q.pop_front();
            obs = {hb_state, busy, rx_en, done};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL pre_reset cyc %0d: got hb=%0d busy=%b rx_en=%b done=%b, want hb=%0d busy=%b rx_en=%b done=%b",
                         c, obs[4:3], obs[2], obs[1], obs[0], exp[4:3], exp[2], exp[1], exp[0]);
            end
        end
        exp_q.delete();
        #2;
        rst = 1'b1;
        #1;
        tests_run++;
        if (hb_state !== HB_HIGHZ) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_hb: got %0d, want %0d", hb_state, HB_HIGHZ);
        end
        tests_run++;
        if (busy !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL mid_reset_busy: got %b, want 0", busy);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive_lens(0, 2, 0, 1);
        start = 1'b1;
        model_ping(0, 2, 0, 1, 0, -1);
        exp_q.push_back(V_IDLE);
        c = 0;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            start = 1'b0;
            exp = exp_q.pop_front();
            obs = {hb_state, busy, rx_en, done};
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("[TB] FAIL post_reset cyc %0d: got hb=%0d busy=%b rx_en=%b done=%b, want hb=%0d busy=%b rx_en=%b done=%b",
                         c, obs[4:3], obs[2], obs[1], obs[0], exp[4:3], exp[2], exp[1], exp[0]);
            end
            c++;
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        drive_lens(0, 0, 0, 0);
        test_reset();
        test_phases();
        test_abort();
        test_back_to_back();
        test_reset_mid_burst();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
